// File: rtl/mttkrp_shard_scheduler.sv
// +--------------------------------------------------------------------------+
// | mttkrp_shard_scheduler                                                   |
// | Round-robin shard dispatcher feeding mirrored MTTKRP compute units.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mttkrp_shard_scheduler #(
  parameter int TENSOR_WIDTH    = 128,
  parameter int NUM_CU          = 4,
  parameter int SHARD_LEN_WIDTH = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shard_desc_valid,
  output logic                       shard_desc_ready,
  input  logic [SHARD_LEN_WIDTH-1:0] shard_desc_len,
  input  logic                       tensor_in_valid,
  output logic                       tensor_in_ready,
  input  logic [TENSOR_WIDTH-1:0]    tensor_in_data,
  input  logic [NUM_CU-1:0]          cu_ready_receive_tensor,
  input  logic [NUM_CU-1:0]          cu_op_done_ack,
  output logic [NUM_CU-1:0]          cu_begining_of_shard,
  output logic [NUM_CU-1:0]          cu_end_of_shard,
  output logic [NUM_CU-1:0]          cu_tensor_element_en,
  output logic [TENSOR_WIDTH-1:0]    cu_tensor_element,
  output logic                       busy,
  output logic                       ack_error
);

  localparam int c_sel_w  = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;
  localparam int c_pend_w = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_begin  = 2'd1;
  localparam logic [1:0] c_st_stream = 2'd2;
  localparam logic [1:0] c_st_end    = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [c_sel_w-1:0]         sel_q, sel_d;
  logic [c_sel_w-1:0]         rr_q, rr_d;
  logic [SHARD_LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [c_pend_w-1:0]        pending_q [NUM_CU];
  logic [c_pend_w-1:0]        pending_d [NUM_CU];
  logic [NUM_CU-1:0]          begin_q, begin_d;
  logic [NUM_CU-1:0]          end_q, end_d;
  logic [NUM_CU-1:0]          en_q, en_d;
  logic [TENSOR_WIDTH-1:0]    elem_q, elem_d;
  logic                       busy_q, busy_d;
  logic                       ack_error_q, ack_error_d;

  logic [NUM_CU-1:0]          eligible;
  logic [NUM_CU-1:0]          sel_onehot;
  logic [NUM_CU-1:0]          inc_vec;
  logic [c_sel_w-1:0]         pick_sel;
  logic                       pick_found;
  logic                       any_pending;

  always_comb begin
    for (int i = 0; i < NUM_CU; i++) begin
      eligible[i]   = cu_ready_receive_tensor[i] &&
                      (pending_q[i] < c_pend_w'(MAX_OUTSTANDING));
      sel_onehot[i] = (sel_q == c_sel_w'(i));
    end
  end

  // Search starts at rr_q and wraps, so the unit after the last served one wins ties.
  always_comb begin
    pick_sel   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_CU; k++) begin
      if (!pick_found && eligible[(int'(rr_q) + k) % NUM_CU]) begin
        pick_found = 1'b1;
        pick_sel   = c_sel_w'((int'(rr_q) + k) % NUM_CU);
      end
    end
  end

  assign shard_desc_ready = (state_q == c_st_idle) && (|eligible);
  assign tensor_in_ready  = (state_q == c_st_stream) && (|(cu_ready_receive_tensor & sel_onehot));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_d        = rr_q;
    remaining_d = remaining_q;
    begin_d     = '0;
    end_d       = '0;
    en_d        = '0;
    elem_d      = elem_q;
    case (state_q)
      c_st_idle: begin
        if (shard_desc_valid && shard_desc_ready) begin
          remaining_d = shard_desc_len;
          sel_d       = pick_sel;
          state_d     = c_st_begin;
        end
      end
      c_st_begin: begin
        begin_d = sel_onehot;
        state_d = (remaining_q != '0) ? c_st_stream : c_st_end;
      end
      c_st_stream: begin
        if (tensor_in_valid && tensor_in_ready) begin
          en_d        = sel_onehot;
          elem_d      = tensor_in_data;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == SHARD_LEN_WIDTH'(1)) begin
            state_d = c_st_end;
          end
        end
      end
      c_st_end: begin
        end_d   = sel_onehot;
        rr_d    = (sel_q == c_sel_w'(NUM_CU - 1)) ? '0 : sel_q + 1'b1;
        state_d = c_st_idle;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // A dispatch and an ack landing on the same unit in one cycle cancel out.
  always_comb begin
    inc_vec     = (state_q == c_st_begin) ? sel_onehot : '0;
    ack_error_d = ack_error_q;
    any_pending = 1'b0;
    for (int i = 0; i < NUM_CU; i++) begin
      pending_d[i] = pending_q[i];
      if (inc_vec[i] && !cu_op_done_ack[i]) begin
        pending_d[i] = pending_q[i] + 1'b1;
      end else if (!inc_vec[i] && cu_op_done_ack[i]) begin
        if (pending_q[i] == '0) begin
          ack_error_d = 1'b1;
        end else begin
          pending_d[i] = pending_q[i] - 1'b1;
        end
      end
      any_pending = any_pending || (pending_d[i] != '0);
    end
    busy_d = (state_d != c_st_idle) || any_pending;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_st_idle;
      sel_q       <= '0;
      rr_q        <= '0;
      remaining_q <= '0;
      begin_q     <= '0;
      end_q       <= '0;
      en_q        <= '0;
      elem_q      <= '0;
      busy_q      <= 1'b0;
      ack_error_q <= 1'b0;
      for (int i = 0; i < NUM_CU; i++) begin
        pending_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      remaining_q <= remaining_d;
      begin_q     <= begin_d;
      end_q       <= end_d;
      en_q        <= en_d;
      elem_q      <= elem_d;
      busy_q      <= busy_d;
      ack_error_q <= ack_error_d;
      for (int i = 0; i < NUM_CU; i++) begin
        pending_q[i] <= pending_d[i];
      end
    end
  end

  assign cu_begining_of_shard = begin_q;
  assign cu_end_of_shard      = end_q;
  assign cu_tensor_element_en = en_q;
  assign cu_tensor_element    = elem_q;
  assign busy                 = busy_q;
  assign ack_error            = ack_error_q;

endmodule

`default_nettype wire

// File: tb/tb_mttkrp_shard_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_mttkrp_shard_scheduler                                                |
// | Directed self-checking bench for the shard scheduler.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mttkrp_shard_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         shard_desc_valid;
  logic         shard_desc_ready;
  logic [15:0]  shard_desc_len;
  logic         tensor_in_valid;
  logic         tensor_in_ready;
  logic [127:0] tensor_in_data;
  logic [3:0]   cu_ready_receive_tensor;
  logic [3:0]   cu_op_done_ack;
  logic [3:0]   cu_begining_of_shard;
  logic [3:0]   cu_end_of_shard;
  logic [3:0]   cu_tensor_element_en;
  logic [127:0] cu_tensor_element;
  logic         busy;
  logic         ack_error;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] BASE_A = {4{32'hA5A5_0100}};
  localparam logic [127:0] BASE_B = {4{32'h1234_5678}};
  localparam logic [127:0] BASE_C = {4{32'h0C0C_0000}};
  localparam logic [127:0] BASE_D = {4{32'hDEAD_BE00}};
  localparam logic [127:0] BASE_E = {4{32'h0E0E_F000}};

  always #5 clk = ~clk;

  mttkrp_shard_scheduler #(
    .TENSOR_WIDTH(128), .NUM_CU(4), .SHARD_LEN_WIDTH(16), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .shard_desc_valid(shard_desc_valid), .shard_desc_ready(shard_desc_ready),
    .shard_desc_len(shard_desc_len),
    .tensor_in_valid(tensor_in_valid), .tensor_in_ready(tensor_in_ready),
    .tensor_in_data(tensor_in_data),
    .cu_ready_receive_tensor(cu_ready_receive_tensor), .cu_op_done_ack(cu_op_done_ack),
    .cu_begining_of_shard(cu_begining_of_shard), .cu_end_of_shard(cu_end_of_shard),
    .cu_tensor_element_en(cu_tensor_element_en), .cu_tensor_element(cu_tensor_element),
    .busy(busy), .ack_error(ack_error)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int u);
    logic [3:0] one;
    one = 4'b0001;
    return one << u;
  endfunction

  // Full shard: descriptor, begin pulse, elements base+e, end pulse.
  // stall_at >= 0 drops the unit's ready for 3 cycles before that element.
  task automatic run_shard(input int len, input int unit, input logic [127:0] base,
                           input int stall_at, input logic [3:0] ack_mask);
    int n = 0;
    shard_desc_len   = 16'(len);
    shard_desc_valid = 1'b1;
    #1;
    while (!shard_desc_ready && n < 50) begin
      tick();
      n++;
    end
    chk("desc_ready", {127'd0, shard_desc_ready}, 128'd1);
    tick();
    shard_desc_valid = 1'b0;
    cu_op_done_ack   = ack_mask;
    if (len == 0) tensor_in_valid = 1'b1;
    #1;
    chk("busy_in_begin", {127'd0, busy}, 128'd1);
    chk("in_ready_begin", {127'd0, tensor_in_ready}, 128'd0);
    chk("no_early_begin", {124'd0, cu_begining_of_shard}, 128'd0);
    tick();
    cu_op_done_ack = 4'b0000;
    chk("begin_pulse", {124'd0, cu_begining_of_shard}, {124'd0, oh(unit)});
    chk("no_end_at_begin", {124'd0, cu_end_of_shard}, 128'd0);
    for (int e = 0; e < len; e++) begin
      if (e == stall_at) begin
        cu_ready_receive_tensor[unit] = 1'b0;
        tensor_in_valid = 1'b1;
        tensor_in_data  = base + 128'(e);
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("stall_in_ready", {127'd0, tensor_in_ready}, 128'd0);
          tick();
          chk("stall_no_strobe", {124'd0, cu_tensor_element_en}, 128'd0);
        end
        cu_ready_receive_tensor[unit] = 1'b1;
      end
      tensor_in_valid = 1'b1;
      tensor_in_data  = base + 128'(e);
      #1;
      chk("in_ready", {127'd0, tensor_in_ready}, 128'd1);
      tick();
      chk("strobe", {124'd0, cu_tensor_element_en}, {124'd0, oh(unit)});
      chk("element", cu_tensor_element, base + 128'(e));
      chk("no_end_with_strobe", {124'd0, cu_end_of_shard}, 128'd0);
      chk("begin_one_cycle", {124'd0, cu_begining_of_shard}, 128'd0);
    end
    if (len == 0) chk("zero_len_in_ready", {127'd0, tensor_in_ready}, 128'd0);
    tensor_in_valid = 1'b0;
    tick();
    chk("end_pulse", {124'd0, cu_end_of_shard}, {124'd0, oh(unit)});
    chk("no_strobe_at_end", {124'd0, cu_tensor_element_en}, 128'd0);
    tick();
    chk("end_one_cycle", {124'd0, cu_end_of_shard}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    shard_desc_valid = 1'b0;
    shard_desc_len = 16'd0;
    tensor_in_valid = 1'b0;
    tensor_in_data = 128'd0;
    cu_ready_receive_tensor = 4'b1111;
    cu_op_done_ack = 4'b0000;
    repeat (2) tick();
    chk("rst_begin", {124'd0, cu_begining_of_shard}, 128'd0);
    chk("rst_end", {124'd0, cu_end_of_shard}, 128'd0);
    chk("rst_en", {124'd0, cu_tensor_element_en}, 128'd0);
    chk("rst_elem", cu_tensor_element, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_ack_error", {127'd0, ack_error}, 128'd0);
    rst = 1'b0;
    #1;
    chk("idle_desc_ready", {127'd0, shard_desc_ready}, 128'd1);
    chk("idle_in_ready", {127'd0, tensor_in_ready}, 128'd0);

    // Single shard of 4 to unit 0, then ack it.
    run_shard(4, 0, BASE_A, -1, 4'b0000);
    chk("pending0_busy", {127'd0, busy}, 128'd1);
    cu_op_done_ack = 4'b0001;
    tick();
    cu_op_done_ack = 4'b0000;
    chk("ack0_busy", {127'd0, busy}, 128'd0);
    chk("ack0_no_error", {127'd0, ack_error}, 128'd0);

    // Async reset mid-stream of an 8-element shard on unit 1.
    shard_desc_len = 16'd8;
    shard_desc_valid = 1'b1;
    #1;
    tick();
    shard_desc_valid = 1'b0;
    tick();
    chk("mid_begin_unit1", {124'd0, cu_begining_of_shard}, 128'h2);
    for (int e = 0; e < 3; e++) begin
      tensor_in_valid = 1'b1;
      tensor_in_data = BASE_B + 128'(e);
      tick();
      chk("mid_strobe", {124'd0, cu_tensor_element_en}, 128'h2);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_en", {124'd0, cu_tensor_element_en}, 128'd0);
    chk("mid_rst_elem", cu_tensor_element, 128'd0);
    chk("mid_rst_end", {124'd0, cu_end_of_shard}, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_in_ready", {127'd0, tensor_in_ready}, 128'd0);
    tensor_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("abandon_no_end", {124'd0, cu_end_of_shard}, 128'd0);
    chk("abandon_busy", {127'd0, busy}, 128'd0);

    // Round-robin over 8 shards fills every unit to MAX_OUTSTANDING.
    for (int s = 0; s < 8; s++) begin
      run_shard(2, s % 4, BASE_C + 128'(s * 16), -1, 4'b0000);
    end
    shard_desc_len = 16'd2;
    shard_desc_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("full_desc_stall", {127'd0, shard_desc_ready}, 128'd0);
      tick();
      chk("full_no_begin", {124'd0, cu_begining_of_shard}, 128'd0);
    end
    cu_op_done_ack = 4'b0100;
    tick();
    cu_op_done_ack = 4'b0000;
    #1;
    chk("freed_desc_ready", {127'd0, shard_desc_ready}, 128'd1);
    run_shard(2, 2, BASE_C + 128'h100, -1, 4'b0000);
    cu_op_done_ack = 4'b1111;
    repeat (2) tick();
    cu_op_done_ack = 4'b0000;
    chk("drain_busy", {127'd0, busy}, 128'd0);
    chk("drain_no_error", {127'd0, ack_error}, 128'd0);

    // Zero-length shard lands on unit 3.
    run_shard(0, 3, 128'd0, -1, 4'b0000);
    chk("zero_pending_busy", {127'd0, busy}, 128'd1);
    cu_op_done_ack = 4'b1000;
    tick();
    cu_op_done_ack = 4'b0000;
    chk("zero_ack_busy", {127'd0, busy}, 128'd0);

    // Backpressure before element 2 of a 4-element shard on unit 0.
    run_shard(4, 0, BASE_D, 2, 4'b0000);
    chk("bp_busy", {127'd0, busy}, 128'd1);

    // Only unit 0 ready: dispatch collides with its ack, pending stays 1.
    cu_ready_receive_tensor = 4'b0001;
    run_shard(1, 0, BASE_E, -1, 4'b0001);
    cu_ready_receive_tensor = 4'b1111;
    chk("collide_busy", {127'd0, busy}, 128'd1);
    chk("collide_no_error", {127'd0, ack_error}, 128'd0);
    cu_op_done_ack = 4'b0001;
    tick();
    cu_op_done_ack = 4'b0000;
    chk("collide_ack_busy", {127'd0, busy}, 128'd0);
    chk("collide_ack_no_error", {127'd0, ack_error}, 128'd0);
    cu_op_done_ack = 4'b0010;
    tick();
    cu_op_done_ack = 4'b0000;
    chk("stray_ack_error", {127'd0, ack_error}, 128'd1);
    chk("stray_busy", {127'd0, busy}, 128'd0);
    tick();
    chk("ack_error_sticky", {127'd0, ack_error}, 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ack_error_cleared", {127'd0, ack_error}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
